dcache_direct: RTL and testbench
================================

Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU's memory stage and a slower word-addressed backing data memory.
- Read hits return data combinationally in the same cycle.
- Read misses and all stores hold the pipeline via `stall` while a request/acknowledge handshake runs to backing memory.
- Provides hit and miss counters for benchmarking the pipelined core.

Parameters:
- WIDTH, 32: data and address width in bits.
- INDEX_BITS, 4: log2 of line count; 16 lines, one 32-bit word per line.
- TAG_BITS, WIDTH-INDEX_BITS-2: stored tag width, address bits [31:INDEX_BITS+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  memory-stage access request this cycle.
- write_enable  in  1  1 = store, 0 = load; qualified by `req_valid`.
- address  in  WIDTH  byte address; bits [1:0] ignored (word-aligned).
- write_data  in  WIDTH  store data, already lane-aligned by the memory stage.
- byte_mask  in  4  store byte enables, bit i covers byte lane i.
- read_data  out  WIDTH  load result, valid when `req_valid & !write_enable & !stall`.
- stall  out  1  hold the pipeline; memory-stage inputs stay stable while high.
- mem_req  out  1  backing-memory request; held until `mem_ack`.
- mem_we  out  1  backing write (1) or read (0).
- mem_addr  out  WIDTH  word-aligned backing address, {address[31:2], 2'b00}.
- mem_wdata  out  WIDTH  backing write data.
- mem_wmask  out  4  backing write byte enables.
- mem_ack  in  1  one-cycle pulse: request done; for reads, `mem_rdata` is valid that cycle.
- mem_rdata  in  WIDTH  backing read data.
- hit_count  out  32  completed read hits; wraps at 2^32.
- miss_count  out  32  read misses; wraps at 2^32.

Behaviour:
- Storage: per line one valid bit, TAG_BITS tag, WIDTH data word. Index = address[INDEX_BITS+1:2].
- Hit condition: `valid[index]` set and stored tag equals address tag.
- Reset:
  - all valid bits cleared, state IDLE.
  - `mem_req`, `mem_we`, `mem_wmask` 0; `mem_addr`, `mem_wdata` 0.
  - `hit_count`, `miss_count` 0.
  - data and tag arrays are not reset.
- State machine: IDLE, FILL, WRITE.
- IDLE, no request: `stall` = 0, `mem_req` = 0.
- IDLE, read hit:
  - `read_data` = line data combinationally, `stall` = 0, zero added latency.
  - `hit_count` increments at the clock edge.
- IDLE, read miss:
  - `stall` = 1 combinationally.
  - Next edge: go to FILL, register `mem_addr`, `mem_we` = 0, `mem_req` = 1, `miss_count` increments.
- FILL:
  - `stall` = 1; `mem_req` stays high until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` into the line, set tag and valid, drop `mem_req`, return to IDLE.
  - Next cycle the request hits: `read_data` comes from the cache, `stall` = 0, `hit_count` increments.
  - Minimum miss cost: ack latency + 2 stall cycles.
- IDLE, store (hit or miss):
  - `stall` = 1.
  - Next edge: go to WRITE, register `mem_addr`/`mem_wdata`/`mem_wmask`, `mem_we` = 1, `mem_req` = 1.
  - On a store hit, masked bytes of the cached word are updated at that same edge.
  - A store miss does not allocate.
- WRITE:
  - `stall` = 1 until `mem_ack`; then `mem_req` = 0 and return to IDLE.
  - Store completion cycle: `stall` = 0 for one cycle. A store is retired when IDLE sees it a second time with a `done` flag set; `done` clears when `stall` = 0.
  - `byte_mask` = 0 still performs the handshake and changes no data.
- `mem_ack` arriving in IDLE (stale, or after reset) is ignored.
- Reset mid-FILL or mid-WRITE: transaction abandoned, no line installed, `mem_req` low next cycle.
- Aliasing: two addresses with the same index and different tags evict each other; the fill overwrites tag and data.
- `read_data` when not a valid read hit: drive the indexed line data (don't-care to pipeline, deterministic for the bench).
- Counters are plain free-running adders with wrap; they never saturate.

Decomposition:
- Package dcache_pkg:
  - state enum `dcache_state_t` {IDLE, FILL, WRITE}.
  - INDEX_BITS default and tag/index slice helper functions.
- One sub-module, `dcache_array`: valid/tag/data storage.
  - Combinational read port.
  - Fill write port.
  - Byte-masked write port.
  - Synchronous valid clear on `rst`.
- FSM, backing-memory handshake, and counters stay in `dcache_direct`.

Test Plan:
1. Reset, then load 0x0000_0040; backing memory acks 3 cycles after `mem_req` with 0xDEAD_BEEF -> `stall` high 5 cycles, `read_data` = 0xDEADBEEF on the first non-stall cycle, `miss_count` = 1, `hit_count` = 1.
2. Repeat load 0x40 -> `stall` = 0 same cycle, `read_data` 0xDEADBEEF, no `mem_req`, `hit_count` = 2.
3. Store 0x0000_00AA to 0x40 with mask 4'b0001 -> `mem_we` = 1, `mem_wmask` = 0001, `mem_addr` = 0x40 until ack; subsequent load 0x40 hits with 0xDEADBEAA.
4. Load 0x0000_0080 (same index as 0x40, different tag) misses, returns backing value 0x1234_5678; then load 0x40 -> miss again (eviction), `miss_count` increments.
5. Assert `rst` during FILL (before ack), then deliver a late `mem_ack` -> `mem_req` 0 after reset, ack ignored, next load of the same address misses.
6. Store to uncached 0x100 then load 0x100 -> store causes no allocation; the load misses and issues a read `mem_req`.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-slicing helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int INDEX_BITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    // Line index: word address bits just above the byte offset.
    function automatic logic [WIDTH_DEF-1:0] addr_index(input logic [WIDTH_DEF-1:0] addr,
                                                       input int index_bits);
        logic [WIDTH_DEF-1:0] mask;
        mask = (WIDTH_DEF'(1) << index_bits) - WIDTH_DEF'(1);
        return (addr >> 2) & mask;
    endfunction

    // Tag: everything above the index field.
    function automatic logic [WIDTH_DEF-1:0] addr_tag(input logic [WIDTH_DEF-1:0] addr,
                                                     input int index_bits);
        return addr >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// fill port (installs a whole line) and byte-masked store-hit port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [WIDTH-1:0]      fill_data,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [3:0]            wr_mask
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [TAG_BITS-1:0] tag_d  [LINES];
    logic [WIDTH-1:0]    data_q [LINES];
    logic [WIDTH-1:0]    data_d [LINES];

    // Replace only the byte lanes whose enable is set.
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                    input logic [WIDTH-1:0] new_w,
                                                    input logic [3:0]       mask);
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // Next-state of the storage: a fill installs tag/data/valid, a store hit merges bytes.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = fill_tag;
            data_d[idx]  = fill_data;
        end
        if (wr_en) begin
            data_d[idx] = merge_bytes(data_q[idx], wr_data, wr_mask);
        end
    end

    // Valid bits are the only storage cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data words hold whatever was last written; validity gates their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache. Read hits return
// in the same cycle; read misses and all stores stall the pipeline while a
// req/ack handshake runs to backing memory. Counts read hits and misses.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = WIDTH - INDEX_BITS - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] write_data,
    input  logic [3:0]       byte_mask,
    output logic [WIDTH-1:0] read_data,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
);

    dcache_state_t state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;
    logic [31:0]      hit_count_q, hit_count_d;
    logic [31:0]      miss_count_q, miss_count_d;
    logic             done_q, done_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  arr_valid;
    logic [TAG_BITS-1:0]   arr_tag;
    logic [WIDTH-1:0]      arr_data;
    logic                  hit;
    logic                  fill_en;
    logic                  wr_en;

    assign idx = INDEX_BITS'(addr_index(address, INDEX_BITS));
    assign tag = TAG_BITS'(addr_tag(address, INDEX_BITS));
    assign hit = arr_valid && (arr_tag == tag);

    dcache_array #(
        .WIDTH      (WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data),
        .fill_en   (fill_en),
        .fill_tag  (tag),
        .fill_data (mem_rdata),
        .wr_en     (wr_en),
        .wr_data   (write_data),
        .wr_mask   (byte_mask)
    );

    // Indexed line is always presented; the pipeline only uses it on a hit.
    assign read_data  = arr_data;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Controller: hit/miss decision, backing-memory handshake and counters.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        done_d       = done_q;
        stall        = 1'b0;
        fill_en      = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (write_enable) begin
                        // A store seen again after its ack is the retiring cycle.
                        if (!done_q) begin
                            stall       = 1'b1;
                            state_d     = WRITE;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {address[WIDTH-1:2], 2'b00};
                            mem_wdata_d = write_data;
                            mem_wmask_d = byte_mask;
                            wr_en       = hit;
                        end
                    end else if (hit) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end else begin
                        stall        = 1'b1;
                        state_d      = FILL;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = {address[WIDTH-1:2], 2'b00};
                        miss_count_d = miss_count_q + 32'd1;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    fill_en   = !rst;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (!stall) begin
            done_d = 1'b0;
        end
    end

    // Control and handshake registers; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 4'b0000;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: stimulus pushes expected load data and
// expected backing-memory transactions; a negedge monitor pops and compares.
module tb_dcache_direct;

    localparam int ACK_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_mask;
    logic [31:0] read_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    mreq_t       mreq_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] bmem [logic [31:0]];
    bit          resp_en;
    bit          inject_ack;

    dcache_direct dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .byte_mask    (byte_mask),
        .read_data    (read_data),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Backing memory: acks on the (ACK_LAT+1)th cycle mem_req is seen high.
    initial begin : responder
        int          wait_cnt;
        logic [31:0] w;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (inject_ack) begin
                mem_ack    = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
                inject_ack = 1'b0;
            end else if (resp_en && mem_req) begin
                wait_cnt++;
                if (wait_cnt == ACK_LAT + 1) begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    w = bmem.exists(mem_addr) ? bmem[mem_addr] : 32'h0;
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (mem_wmask[i]) w[i*8 +: 8] = mem_wdata[i*8 +: 8];
                        end
                        bmem[mem_addr] = w;
                    end else begin
                        mem_rdata = w;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: completed loads and every cycle of an open backing request.
    always @(negedge clk) begin : monitor
        mreq_t       e;
        logic [31:0] exp_rd;
        if (!rst && req_valid && !write_enable && !stall) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=0x%08h required=no_load_completion", read_data);
            end else begin
                exp_rd = rd_q.pop_front();
                check("read_data", read_data, exp_rd);
            end
        end
        if (mem_req) begin
            if (mreq_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mreq_unexpected actual_addr=0x%08h required=no_request", mem_addr);
            end else begin
                e = mreq_q[0];
                check("mem_we", 32'(mem_we), 32'(e.we));
                check("mem_addr", mem_addr, e.addr);
                if (e.we) begin
                    check("mem_wdata", mem_wdata, e.wdata);
                    check("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
                end
                if (mem_ack) void'(mreq_q.pop_front());
            end
        end
    end

    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] m, output int stalls);
        bit fin;
        stalls = 0;
        fin    = 1'b0;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        write_enable = we;
        address      = addr;
        write_data   = wd;
        byte_mask    = m;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            else fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL access_timeout actual=stall_stuck required=completion addr=0x%08h", addr);
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_data, input bit miss);
        int st;
        rd_q.push_back(exp_data);
        if (miss) mreq_q.push_back('{we: 1'b0, addr: addr, wdata: 32'h0, wmask: 4'h0});
        run_access(1'b0, addr, 32'h0, 4'h0, st);
        check(miss ? "load_miss_stalls" : "load_hit_stalls", st, miss ? 32'd5 : 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] m);
        int st;
        mreq_q.push_back('{we: 1'b1, addr: addr, wdata: data, wmask: m});
        run_access(1'b1, addr, data, m, st);
        check("store_stalls", st, 32'd5);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst          = 1'b1;
        req_valid    = 1'b0;
        write_enable = 1'b0;
        address      = 32'h0;
        write_data   = 32'h0;
        byte_mask    = 4'h0;
        resp_en      = 1'b1;
        inject_ack   = 1'b0;
        bmem[32'h0000_0040] = 32'hDEAD_BEEF;
        bmem[32'h0000_0080] = 32'h1234_5678;
        bmem[32'h0000_0200] = 32'h0BAD_F00D;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        check("idle_stall", 32'(stall), 32'd0);

        // Cold miss then fill-hit.
        do_load(32'h40, 32'hDEAD_BEEF, 1'b1);
        check("t1_miss_count", miss_count, 32'd1);
        check("t1_hit_count", hit_count, 32'd1);

        // Plain hit.
        do_load(32'h40, 32'hDEAD_BEEF, 1'b0);
        check("t2_hit_count", hit_count, 32'd2);
        check("t2_miss_count", miss_count, 32'd1);

        // Store hit, low byte only.
        do_store(32'h40, 32'h0000_00AA, 4'b0001);
        check("t3_hit_count", hit_count, 32'd2);
        do_load(32'h40, 32'hDEAD_BEAA, 1'b0);
        check("t3_hit_after", hit_count, 32'd3);

        // Empty byte mask: handshake happens, data unchanged.
        do_store(32'h40, 32'hFFFF_FFFF, 4'b0000);
        do_load(32'h40, 32'hDEAD_BEAA, 1'b0);
        check("mask0_hit_count", hit_count, 32'd4);

        // Aliasing eviction on index 0.
        do_load(32'h80, 32'h1234_5678, 1'b1);
        check("t4_miss_count_a", miss_count, 32'd2);
        do_load(32'h40, 32'hDEAD_BEAA, 1'b1);
        check("t4_miss_count_b", miss_count, 32'd3);
        check("t4_hit_count", hit_count, 32'd6);

        // Reset during FILL, then a stale ack.
        resp_en = 1'b0;
        mreq_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, wmask: 4'h0});
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        write_enable = 1'b0;
        address      = 32'h200;
        @(negedge clk);
        check("t5_miss_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_fill_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_req_after_rst", 32'(mem_req), 32'd0);
        check("t5_hit_after_rst", hit_count, 32'd0);
        check("t5_miss_after_rst", miss_count, 32'd0);
        mreq_q.delete();
        inject_ack = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_stale_ack_seen", 32'(mem_ack), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_req_after_ack", 32'(mem_req), 32'd0);
        resp_en = 1'b1;
        do_load(32'h200, 32'h0BAD_F00D, 1'b1);
        check("t5_miss_count", miss_count, 32'd1);
        check("t5_hit_count", hit_count, 32'd1);

        // Store miss does not allocate.
        do_store(32'h100, 32'hCAFE_F00D, 4'b1111);
        check("t6_miss_before", miss_count, 32'd1);
        do_load(32'h100, 32'hCAFE_F00D, 1'b1);
        check("t6_miss_count", miss_count, 32'd2);
        check("t6_hit_count", hit_count, 32'd2);

        repeat (2) @(posedge clk);
        check("rd_queue_empty", rd_q.size(), 32'd0);
        check("mreq_queue_empty", mreq_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
